// File: rtl/shape_color_classifier_if.sv
// Processing read port of the frame buffer: the classifier drives the address,
// and the buffer returns the pixel one clock later.
interface shape_color_classifier_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic [AW-1:0] proc_addr_in;
    logic [DW-1:0] proc_data_in;

    modport master (output proc_addr_in, input proc_data_in);
    modport slave  (input proc_addr_in, output proc_data_in);
endinterface

// File: rtl/shape_color_classifier.sv
// Two-pass scan of a stored RGB444 frame that reports the dominant object colour and a coarse shape.
// Define SHAPE_DETECT_EN to build the second pass and the shape decision; otherwise only colour is reported.
module shape_color_classifier #(
    parameter int          AW         = 15,
    parameter int          DW         = 12,
    parameter int          IMG_W      = 160,
    parameter int          IMG_H      = 120,
    parameter logic [3:0]  COLOR_MIN  = 4'd8,
    parameter logic [14:0] MIN_PIXELS = 15'd64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_procesamiento,
    shape_color_classifier_if.master buf_port,
    output logic [1:0]               color,
    output logic [1:0]               figure,
    output logic                     done,
    output logic                     busy
);
    localparam int            N        = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_IDX = AW'(N);

    typedef enum logic [2:0] {IDLE, PASS1, PASS2, CLASSIFY, DONE} state_t;

    state_t        state, state_nxt;
    logic          init_q, start_q;
    logic [AW-1:0] idx;
    logic [14:0]   cnt_r, cnt_g, cnt_b;
    logic [1:0]    pix_cls, winner;
    logic          scanning, data_valid, pass_end, start_accept;

    function automatic logic [1:0] classify_pixel(input logic [DW-1:0] p);
        logic [3:0] r, g, b;
        r = p[11:8];
        g = p[7:4];
        b = p[3:0];
        if (r >= COLOR_MIN && r > g && r > b)      return 2'd1;
        else if (g >= COLOR_MIN && g > r && g > b) return 2'd2;
        else if (b >= COLOR_MIN && b > r && b > g) return 2'd3;
        else                                       return 2'd0;
    endfunction

    // Strict comparisons keep the earlier channel on ties, giving R > G > B priority.
    function automatic logic [1:0] pick_winner(input logic [14:0] r, input logic [14:0] g,
                                               input logic [14:0] b);
        logic [14:0] best;
        logic [1:0]  w;
        w    = 2'd1;
        best = r;
        if (g > best) begin w = 2'd2; best = g; end
        if (b > best) begin w = 2'd3; best = b; end
        if (best < MIN_PIXELS) w = 2'd0;
        return w;
    endfunction

    assign pix_cls      = classify_pixel(buf_port.proc_data_in);
    assign winner       = pick_winner(cnt_r, cnt_g, cnt_b);
    assign start_accept = start_q && (state == IDLE || state == DONE);
    assign scanning     = (state == PASS1) || (state == PASS2);
    assign pass_end     = scanning && (idx == LAST_IDX);
    assign data_valid   = scanning && (idx != '0);

    // idx runs 0..N-1 as the address, then N is the flush cycle for the read latency.
    assign buf_port.proc_addr_in = (scanning && !pass_end) ? idx : '0;

    // init_q resets high so a request already asserted during reset is not taken as an edge.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q  <= 1'b1;
            start_q <= 1'b0;
        end else begin
            init_q  <= init_procesamiento;
            start_q <= init_procesamiento & ~init_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: next state gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start_q) state_nxt = PASS1;
            PASS1: begin
                if (pass_end) begin
`ifdef SHAPE_DETECT_EN
                    state_nxt = PASS2;
`else
                    state_nxt = CLASSIFY;
`endif
                end
            end
            PASS2:    if (pass_end) state_nxt = CLASSIFY;
            CLASSIFY: state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (start_accept) begin
            idx   <= '0;
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (scanning) begin
            idx <= pass_end ? '0 : idx + 1'b1;
            if (state == PASS1 && data_valid) begin
                unique case (pix_cls)
                    2'd1:    cnt_r <= cnt_r + 15'd1;
                    2'd2:    cnt_g <= cnt_g + 15'd1;
                    2'd3:    cnt_b <= cnt_b + 15'd1;
                    default: ;
                endcase
            end
        end
    end

    // Colour resolves in CLASSIFY in both builds; results move only here or on a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color <= 2'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (start_accept) begin
            color <= 2'd0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else if (state == CLASSIFY) begin
            color <= winner;
            done  <= 1'b1;
            busy  <= 1'b0;
        end
    end

`ifdef SHAPE_DETECT_EN
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0] x, xmin, xmax;
    logic [YW-1:0] y, ymin, ymax;
    logic [14:0]   area, box_w, box_h, box;
    logic [18:0]   area_x16, box_x14, box_x10;
    logic [1:0]    shape;

    // x/y name the pixel whose data is on the bus, one behind idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x    <= '0;
            y    <= '0;
            area <= '0;
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
        end else if (start_accept) begin
            x    <= '0;
            y    <= '0;
            area <= '0;
            xmin <= XW'(IMG_W - 1);
            xmax <= '0;
            ymin <= YW'(IMG_H - 1);
            ymax <= '0;
        end else if (scanning) begin
            if (pass_end) begin
                x <= '0;
                y <= '0;
            end else if (data_valid) begin
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (state == PASS2 && data_valid && winner != 2'd0 && pix_cls == winner) begin
                area <= area + 15'd1;
                if (x < xmin) xmin <= x;
                if (x > xmax) xmax <= x;
                if (y < ymin) ymin <= y;
                if (y > ymax) ymax <= y;
            end
        end
    end

    // Fill ratio area/box: >= 14/16 is a square, >= 10/16 a circle, below that a triangle.
    always_comb begin
        box_w    = 15'(xmax) - 15'(xmin) + 15'd1;
        box_h    = 15'(ymax) - 15'(ymin) + 15'd1;
        box      = box_w * box_h;
        area_x16 = {area, 4'b0000};
        box_x14  = 19'(box) * 19'd14;
        box_x10  = 19'(box) * 19'd10;
        if (winner == 2'd0)         shape = 2'd0;
        else if (area_x16 >= box_x14) shape = 2'd3;
        else if (area_x16 >= box_x10) shape = 2'd2;
        else                          shape = 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  figure <= 2'd0;
        else if (start_accept)     figure <= 2'd0;
        else if (state == CLASSIFY) figure <= shape;
    end
`else
    assign figure = 2'd0;
`endif

endmodule

// File: tb/tb_shape_color_classifier.sv
// Self-checking bench: random frames in a behavioural buffer, expectations from a whole-frame reference model.
module tb_shape_color_classifier;
    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;
`ifdef SHAPE_DETECT_EN
    localparam int EXP_LAT = 2 * N + 4;
`else
    localparam int EXP_LAT = N + 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init = 1'b0;
    logic [1:0] color, figure;
    logic       done, busy;
    logic [11:0] frame [0:32767];
    int checks = 0;
    int errors = 0;

    shape_color_classifier_if #(.AW(15), .DW(12)) bus ();

    shape_color_classifier #(
        .AW(15), .DW(12), .IMG_W(W), .IMG_H(H), .COLOR_MIN(4'd8), .MIN_PIXELS(15'd64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init_procesamiento(init),
        .buf_port(bus),
        .color(color),
        .figure(figure),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.proc_data_in <= frame[bus.proc_addr_in];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        if (r >= 8 && r > g && r > b) return 1;
        if (g >= 8 && g > r && g > b) return 2;
        if (b >= 8 && b > r && b > g) return 3;
        return 0;
    endfunction

    // A pixel whose channel c dominates with a value of at least 8.
    function automatic logic [11:0] hue(input int c);
        logic [3:0] d, a, e;
        d = 4'($urandom_range(8, 15));
        a = 4'($urandom_range(0, int'(d) - 1));
        e = 4'($urandom_range(0, int'(d) - 1));
        if (c == 1) return {d, a, e};
        if (c == 2) return {a, d, e};
        return {a, e, d};
    endfunction

    // Dim noise: every channel below 8, so never counted as coloured.
    task automatic fill_noise();
        for (int p = 0; p < N; p++)
            frame[p] = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
    endtask

    task automatic model(output int ec, output int ef);
        int cnt[4];
        int area, x0, x1, y0, y1, box;
        cnt = '{0, 0, 0, 0};
        for (int p = 0; p < N; p++) cnt[cls_of(frame[p])]++;
        ec = 1;
        if (cnt[2] > cnt[ec]) ec = 2;
        if (cnt[3] > cnt[ec]) ec = 3;
        if (cnt[ec] < 64) ec = 0;
        ef = 0;
        if (ec != 0) begin
            area = 0; x0 = W; x1 = -1; y0 = H; y1 = -1;
            for (int p = 0; p < N; p++) begin
                if (cls_of(frame[p]) == ec) begin
                    area++;
                    if (p % W < x0) x0 = p % W;
                    if (p % W > x1) x1 = p % W;
                    if (p / W < y0) y0 = p / W;
                    if (p / W > y1) y1 = p / W;
                end
            end
            box = (x1 - x0 + 1) * (y1 - y0 + 1);
            if (area * 16 >= box * 14)      ef = 3;
            else if (area * 16 >= box * 10) ef = 2;
            else                            ef = 1;
        end
`ifndef SHAPE_DETECT_EN
        ef = 0;
`endif
    endtask

    // Cycle c = the value seen just after the c-th rising edge, edge 0 being the one that sees the start.
    task automatic run_frame(input string tag, input bit restart_glitch);
        int ec, ef, lat, noisy;
        model(ec, ef);
        @(negedge clk); init = 1'b0;
        @(negedge clk); init = 1'b1;
        lat = -1;
        noisy = 0;
        for (int cyc = 0; cyc < 2 * EXP_LAT && lat < 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                check({tag, "_busy_c1"}, 32'(busy), 1);
                check({tag, "_addr_c1"}, 32'(bus.proc_addr_in), 0);
            end
            if (cyc == 2) check({tag, "_addr_c2"}, 32'(bus.proc_addr_in), 1);
            if (restart_glitch && cyc == 50) init = 1'b0;
            if (restart_glitch && cyc == 100) init = 1'b1;
            if (cyc >= 1 && done) lat = cyc;
            else if (cyc >= 1 && (color != 2'd0 || figure != 2'd0 || busy != 1'b1)) noisy++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
        check({tag, "_quiet_scan"}, 32'(noisy), 0);
        check({tag, "_color"}, 32'(color), 32'(ec));
        check({tag, "_figure"}, 32'(figure), 32'(ef));
        check({tag, "_busy_end"}, 32'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_hold_done"}, 32'(done), 1);
        check({tag, "_hold_color"}, 32'(color), 32'(ec));
    endtask

    initial begin
        int cx, cy, r, len, ox, oy, rw, rh, c;

        // Reset with the start request already high.
        rst = 1'b0;
        init = 1'b1;
        for (int p = 0; p < N; p++) frame[p] = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_color", 32'(color), 0);
        check("rst_figure", 32'(figure), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(bus.proc_addr_in), 0);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_high_no_start", 32'(busy), 0);

        // Solid red frame.
        for (int p = 0; p < N; p++) frame[p] = 12'hF00;
        run_frame("red_full", 1'b0);

        // Green disk on noise.
        fill_noise();
        cx = $urandom_range(14, 25);
        cy = $urandom_range(12, 17);
        r  = $urandom_range(8, 11);
        for (int p = 0; p < N; p++)
            if ((p % W - cx) * (p % W - cx) + (p / W - cy) * (p / W - cy) <= r * r) frame[p] = hue(2);
        run_frame("green_disk", 1'b0);

        // Blue right triangle on noise.
        fill_noise();
        len = $urandom_range(16, 24);
        ox  = $urandom_range(0, W - len);
        oy  = $urandom_range(0, H - len);
        for (int j = 0; j < len; j++)
            for (int i = 0; i < len - j; i++) frame[(oy + j) * W + ox + i] = hue(3);
        run_frame("blue_tri", 1'b0);

        // Too few red pixels for a detection.
        for (int p = 0; p < N; p++) frame[p] = 12'h000;
        for (int k = 0; k < 40; k++) frame[$urandom_range(0, N - 1)] = hue(1);
        run_frame("sparse_red", 1'b0);

        // Fully random frames.
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < N; p++) frame[p] = 12'($urandom);
            run_frame("random", 1'b0);
        end

        // Random-colour rectangle, with a second start edge at cycle 100 that must be ignored.
        fill_noise();
        c  = $urandom_range(1, 3);
        rw = $urandom_range(8, 20);
        rh = $urandom_range(8, 20);
        ox = $urandom_range(0, W - rw);
        oy = $urandom_range(0, H - rh);
        for (int j = 0; j < rh; j++)
            for (int i = 0; i < rw; i++) frame[(oy + j) * W + ox + i] = hue(c);
        run_frame("restart_ignored", 1'b1);

        // Reset in the middle of a run, start request left high.
        @(negedge clk); init = 1'b0;
        @(negedge clk); init = 1'b1;
        repeat (N / 2) @(posedge clk);
        #2;
        check("busy_before_rst", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_color", 32'(color), 0);
        check("midrst_figure", 32'(figure), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_addr", 32'(bus.proc_addr_in), 0);
        @(negedge clk); rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_restart_busy", 32'(busy), 0);
        check("midrst_no_restart_done", 32'(done), 0);
        run_frame("after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
